// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - byte-serial multi-byte add/subtract sequencer around one 8-bit adder slice
// Operands are processed LSB byte first, one byte per clock, with the carry held in a register.

module Adder_8bits (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       cin,
  output logic [7:0] Sum,
  output logic       cout,
  output logic       overflow
);
  assign {cout, Sum} = {1'b0, A} + {1'b0, B} + {8'd0, cin};
  assign overflow    = (A[7] == B[7]) && (Sum[7] != A[7]);
endmodule

module adder_seq_ctrl #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sub;
  logic            r_carry;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic [7:0]      w_slice_sum;
  logic            w_slice_cout;
  logic            w_slice_ovf;
  logic            w_accept;
  logic            w_last;

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_idx == IW'(NBYTES - 1));

  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_byte = r_a[8*k +: 8];
        w_b_byte = r_b[8*k +: 8];
      end
    end
  end

  // Subtraction runs as A + ~B + 1; the +1 enters through the preset carry register.
  Adder_8bits u_slice (
    .A        (w_a_byte),
    .B        (r_sub ? ~w_b_byte : w_b_byte),
    .cin      (r_carry),
    .Sum      (w_slice_sum),
    .cout     (w_slice_cout),
    .overflow (w_slice_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sub   <= op_sub;
      r_carry <= op_sub ? 1'b1 : cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == S_RUN) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (r_idx == IW'(k)) r_sum[8*k +: 8] <= w_slice_sum;
      end
      r_carry <= w_slice_cout;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_slice_cout;
        r_ovf  <= w_slice_ovf;
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;
endmodule
